packet_sender: RTL and testbench

//  Serializes USB packets requested by the transaction FSMs (out_trans/in_trans) onto a bit stream

---
 rtl/usb_pkg.sv | 32 +++
 rtl/crc_serial.sv | 30 +++
 rtl/packet_sender.sv | 177 +++++++++++++++++
 tb/tb_packet_sender.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB packet sender.
//   pid_t        4-bit packet identifiers used by the sender
//   snd_state_t  sender FSM states
//   SYNC_BYTE, CRC5/CRC16 polynomials and seeds, token field width
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010
    } pid_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_FIELD,
        S_CRC,
        S_DONE
    } snd_state_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'b0000_0001;
    localparam int          CRC5_W      = 5;
    localparam logic [4:0]  CRC5_POLY   = 5'h05;
    localparam logic [4:0]  CRC5_INIT   = 5'h1F;
    localparam int          CRC16_W     = 16;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam int          TOKEN_BITS  = 11;   // addr[6:0] + endp[3:0]

endpackage

// File: rtl/crc_serial.sv
// crc_serial: bit-serial CRC LFSR, one data bit per enabled cycle.
//   clock, reset  clock / async active-high reset (register cleared)
//   i_init        load INIT seed
//   i_en          absorb i_bit
//   i_bit         serial data bit, in wire order
//   o_crc         current residue
module crc_serial #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_init,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_crc
);
    logic [WIDTH-1:0] r_crc;
    logic             w_fb;

    assign w_fb  = i_bit ^ r_crc[WIDTH-1];
    assign o_crc = r_crc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_crc <= '0;
        else if (i_init) r_crc <= INIT;
        else if (i_en)   r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
endmodule

// File: rtl/packet_sender.sv
// packet_sender: serializes OUT/IN tokens, DATA0 and ACK packets into a bit
// stream (SYNC, PID, fields, CRC) with a valid/ready handshake per bit.
//   send_OUT/IN/DATA0/ACK  request pulses, honoured only when idle
//   addr, endp, data       packet contents, latched on acceptance
//   busy                   packet in progress
//   sent                   one-cycle pulse after the final bit is taken
//   out_bit/out_valid      serial bit and its qualifier
//   out_ready              downstream takes out_bit this cycle
//   out_last               marks the final bit of the packet
module packet_sender
    import usb_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    send_OUT,
    input  logic                    send_IN,
    input  logic                    send_DATA0,
    input  logic                    send_ACK,
    input  logic [6:0]              addr,
    input  logic [3:0]              endp,
    input  logic [8*DATA_BYTES-1:0] data,
    output logic                    busy,
    output logic                    sent,
    output logic                    out_bit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);
    localparam int         DW         = 8 * DATA_BYTES;
    localparam int         SHW        = (DW > TOKEN_BITS) ? DW : TOKEN_BITS;
    localparam logic [6:0] FIELD_DATA = 7'(DW);

    snd_state_t     r_state;
    pid_t           r_pid;
    logic [6:0]     r_cnt;
    logic [SHW-1:0] r_shift;
    logic           r_busy, r_sent;

    logic           w_req, w_sel_token, w_is_token, w_adv, w_phase_end;
    pid_t           w_sel;
    logic [SHW-1:0] w_load;
    logic [3:0]     w_pid_bits;
    logic [7:0]     w_pid_byte;
    logic [6:0]     w_field_len, w_crc_len;
    logic [4:0]     w_crc5;
    logic [15:0]    w_crc16;
    logic [2:0]     w_idx5;
    logic [3:0]     w_idx16;

    // Request arbitration: ACK > DATA0 > OUT > IN
    assign w_req = send_ACK | send_DATA0 | send_OUT | send_IN;
    always_comb begin
        w_sel = PID_IN;
        if (send_ACK)        w_sel = PID_ACK;
        else if (send_DATA0) w_sel = PID_DATA0;
        else if (send_OUT)   w_sel = PID_OUT;
    end
    assign w_sel_token = (w_sel == PID_OUT) || (w_sel == PID_IN);

    always_comb begin
        w_load = '0;
        if (w_sel_token) w_load[TOKEN_BITS-1:0] = {endp, addr};
        else             w_load[DW-1:0]         = data;
    end

    assign w_is_token  = (r_pid == PID_OUT) || (r_pid == PID_IN);
    assign w_field_len = w_is_token ? 7'(TOKEN_BITS) : FIELD_DATA;
    assign w_crc_len   = w_is_token ? 7'(CRC5_W) : 7'(CRC16_W);
    assign w_pid_bits  = r_pid;
    assign w_pid_byte  = {~w_pid_bits, w_pid_bits};

    assign out_valid = (r_state == S_SYNC) || (r_state == S_PID) ||
                       (r_state == S_FIELD) || (r_state == S_CRC);
    assign w_adv     = out_valid && out_ready;

    always_comb begin
        w_phase_end = 1'b0;
        case (r_state)
            S_SYNC, S_PID: w_phase_end = (r_cnt == 7'd7);
            S_FIELD:       w_phase_end = (r_cnt == w_field_len - 7'd1);
            S_CRC:         w_phase_end = (r_cnt == w_crc_len - 7'd1);
            default:       w_phase_end = 1'b0;
        endcase
    end

    // CRC is sent complemented, MSB first, from the frozen residue
    assign w_idx5  = 3'd4 - r_cnt[2:0];
    assign w_idx16 = 4'd15 - r_cnt[3:0];

    always_comb begin
        out_bit = 1'b0;
        case (r_state)
            S_SYNC:  out_bit = SYNC_BYTE[r_cnt[2:0]];
            S_PID:   out_bit = w_pid_byte[r_cnt[2:0]];
            S_FIELD: out_bit = r_shift[0];
            S_CRC:   out_bit = w_is_token ? ~w_crc5[w_idx5] : ~w_crc16[w_idx16];
            default: out_bit = 1'b0;
        endcase
    end

    assign out_last = w_phase_end && ((r_state == S_CRC) ||
                      (r_state == S_PID && r_pid == PID_ACK));
    assign busy     = r_busy;
    assign sent     = r_sent;

    crc_serial #(.WIDTH(CRC5_W), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clock  (clock),
        .reset  (reset),
        .i_init (r_state == S_IDLE && w_req),
        .i_en   (r_state == S_FIELD && w_adv && w_is_token),
        .i_bit  (r_shift[0]),
        .o_crc  (w_crc5)
    );

    crc_serial #(.WIDTH(CRC16_W), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clock  (clock),
        .reset  (reset),
        .i_init (r_state == S_IDLE && w_req),
        .i_en   (r_state == S_FIELD && w_adv && !w_is_token),
        .i_bit  (r_shift[0]),
        .o_crc  (w_crc16)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pid   <= PID_OUT;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
            r_sent  <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_pid   <= w_sel;
                    r_shift <= w_load;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_SYNC;
                end
                S_SYNC: if (w_adv) begin
                    r_cnt <= w_phase_end ? 7'd0 : r_cnt + 7'd1;
                    if (w_phase_end) r_state <= S_PID;
                end
                S_PID: if (w_adv) begin
                    r_cnt <= w_phase_end ? 7'd0 : r_cnt + 7'd1;
                    if (w_phase_end) begin
                        if (r_pid == PID_ACK) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_sent  <= 1'b1;
                        end else begin
                            r_state <= S_FIELD;
                        end
                    end
                end
                S_FIELD: if (w_adv) begin
                    r_shift <= r_shift >> 1;
                    r_cnt   <= w_phase_end ? 7'd0 : r_cnt + 7'd1;
                    if (w_phase_end) r_state <= S_CRC;
                end
                S_CRC: if (w_adv) begin
                    r_cnt <= w_phase_end ? 7'd0 : r_cnt + 7'd1;
                    if (w_phase_end) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_sent  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;   // S_DONE: sent pulse cycle
            endcase
        end
    end
endmodule

// File: tb/tb_packet_sender.sv
module tb_packet_sender;
    localparam int DB = 8;

    logic          clock = 1'b0, reset = 1'b1;
    logic          send_OUT = 1'b0, send_IN = 1'b0, send_DATA0 = 1'b0, send_ACK = 1'b0;
    logic [6:0]    addr = '0;
    logic [3:0]    endp = '0;
    logic [8*DB-1:0] data = '0;
    logic          out_ready = 1'b1;
    logic          busy, sent, out_bit, out_valid, out_last;

    packet_sender #(.DATA_BYTES(DB)) dut (
        .clock(clock), .reset(reset),
        .send_OUT(send_OUT), .send_IN(send_IN), .send_DATA0(send_DATA0), .send_ACK(send_ACK),
        .addr(addr), .endp(endp), .data(data),
        .busy(busy), .sent(sent), .out_bit(out_bit), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int cyc = 0, nbits = 0, sent_cnt = 0, busy_cyc = 0, last_cyc = -10, stalls = 0;
    bit stall_en = 1'b0;
    logic [1:0] q[$];   // {last, bit}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // downstream: optional stall one cycle in six
    initial forever begin
        @(posedge clock); #1;
        out_ready = stall_en ? ((cyc % 6) != 5) : 1'b1;
    end

    // scoreboard / monitor
    always @(negedge clock) begin
        logic [1:0] e;
        if (busy) busy_cyc++;
        if (out_valid && !out_ready) stalls++;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("q_empty", 0, 1);
            else begin
                e = q.pop_front();
                chk("bit", out_bit, e[0]);
                chk("last", out_last, e[1]);
            end
            nbits++;
            if (out_last) last_cyc = cyc;
        end
        if (sent) begin
            sent_cnt++;
            chk("sent_lat", cyc, last_cyc + 1);
            chk("busy_at_sent", busy, 0);
        end
    end

    task automatic push_bits(input logic [31:0] v, input int n, input bit last);
        for (int i = 0; i < n; i++) q.push_back({last && (i == n - 1), v[i]});
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) push_bits({24'd0, b[i]}, 8, i == b.size() - 1);
    endtask

    task automatic pulse(input bit o, input bit i, input bit d, input bit a);
        @(posedge clock); #1;
        send_OUT = o; send_IN = i; send_DATA0 = d; send_ACK = a;
        @(posedge clock); #1;
        send_OUT = 0; send_IN = 0; send_DATA0 = 0; send_ACK = 0;
    endtask

    task automatic wait_sent(input int base);
        int n = 0;
        while (sent_cnt == base && n < 2000) begin @(posedge clock); n++; end
        chk("timeout", sent_cnt > base, 1);
        repeat (2) @(posedge clock);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sent"}, sent, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_bit"}, out_bit, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    function automatic logic [4:0] crc5_ref(input logic [10:0] d);
        logic [4:0] c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    initial begin
        int base, nb0, b0, c0, d_plain, d_stall, s0;
        logic [7:0] pkt_out[$]  = '{8'h01, 8'hE1, 8'h00, 8'h10};
        logic [7:0] pkt_ack[$]  = '{8'h01, 8'hD2};
        logic [7:0] pkt_dat[$]  = '{8'h01, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01,
                                    8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        logic [7:0] hdr_in[$]   = '{8'h01, 8'h69};
        logic [63:0] payload    = {8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h06, 8'h80};
        logic [4:0]  c5;

        repeat (3) @(posedge clock); #1;
        chk_idle_outputs("rst");
        reset = 1'b0;

        // OUT token, addr 0 / endp 0
        push_bytes(pkt_out);
        base = sent_cnt; nb0 = nbits;
        pulse(1, 0, 0, 0);
        wait_sent(base);
        chk("out_sent_cnt", sent_cnt - base, 1);
        chk("out_len", nbits - nb0, 32);

        // DATA0, no stalls
        data = payload;
        push_bytes(pkt_dat);
        base = sent_cnt; nb0 = nbits;
        pulse(0, 0, 1, 0);
        c0 = cyc;
        wait_sent(base);
        d_plain = last_cyc - c0;
        chk("dat_len", nbits - nb0, 96);

        // ACK: busy for exactly 16 bits
        push_bytes(pkt_ack);
        base = sent_cnt; nb0 = nbits; b0 = busy_cyc;
        pulse(0, 0, 0, 1);
        wait_sent(base);
        chk("ack_len", nbits - nb0, 16);
        chk("ack_busy", busy_cyc - b0, 16);

        // DATA0 with periodic stalls: same bits, delayed by stall count
        stall_en = 1'b1;
        push_bytes(pkt_dat);
        base = sent_cnt; nb0 = nbits; s0 = stalls;
        pulse(0, 0, 1, 0);
        c0 = cyc;
        wait_sent(base);
        stall_en = 1'b0;
        d_stall = last_cyc - c0;
        chk("stall_len", nbits - nb0, 96);
        chk("stall_seen", (stalls - s0) > 0, 1);
        chk("stall_delay", d_stall - d_plain, stalls - s0);

        // simultaneous OUT+ACK -> ACK; IN while busy is dropped
        push_bytes(pkt_ack);
        base = sent_cnt; nb0 = nbits;
        pulse(1, 0, 0, 1);
        repeat (3) @(posedge clock);
        pulse(0, 1, 0, 0);
        wait_sent(base);
        repeat (60) @(posedge clock);
        chk("prio_sent_cnt", sent_cnt - base, 1);
        chk("prio_len", nbits - nb0, 16);

        // reset during DATA0 at bit 40
        push_bytes(pkt_dat);
        base = sent_cnt; nb0 = nbits;
        pulse(0, 0, 1, 0);
        for (int n = 0; n < 500 && (nbits - nb0) < 40; n++) begin @(posedge clock); #2; end
        chk("rst_at_bit", nbits - nb0, 40);
        reset = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        q.delete();
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        chk("midrst_no_sent", sent_cnt - base, 0);

        // clean OUT after reset
        push_bytes(pkt_out);
        base = sent_cnt; nb0 = nbits;
        pulse(1, 0, 0, 0);
        wait_sent(base);
        chk("post_rst_len", nbits - nb0, 32);

        // IN token with non-trivial addr/endp, CRC5 from reference model
        addr = 7'h15; endp = 4'hE;
        c5 = crc5_ref({endp, addr});
        for (int i = 0; i < hdr_in.size(); i++) push_bits({24'd0, hdr_in[i]}, 8, 1'b0);
        push_bits({21'd0, endp, addr}, 11, 1'b0);
        for (int i = 4; i >= 0; i--) q.push_back({i == 0, ~c5[i]});
        base = sent_cnt; nb0 = nbits;
        pulse(0, 1, 0, 0);
        wait_sent(base);
        chk("in_len", nbits - nb0, 32);

        chk("q_left", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
